// File: rtl/inst_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_responder
// Description : Instruction-memory responder for the IF stage. It accepts a
//               word-address fetch request and returns the instruction word
//               after WAIT_CYCLES wait states. A flush cancels the fetch in
//               flight. The word array is preloaded via the load port while
//               the responder is idle.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [31:0]          req_addr,
    input  logic                 flush,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [31:0]          resp_instr,
    output logic [31:0]          resp_addr,
    output logic                 resp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_WAIT         = 4'(WAIT_CYCLES);
    // With zero wait states an accepted fetch goes straight to the response.
    localparam state_t     c_ACCEPT_STATE = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;

    logic [31:0]          r_mem [DEPTH];
    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_count;
    logic [3:0]           w_count_nxt;
    logic [31:0]          r_addr;
    logic                 r_resp_valid;
    logic [31:0]          r_resp_instr;
    logic [31:0]          r_resp_addr;
    logic                 r_resp_err;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_enter_resp;
    logic [31:0]          w_fetch_addr;
    logic [ADDR_BITS-1:0] w_fetch_idx;
    logic                 w_fetch_misal;
    logic [31:0]          w_fetch_word;

    // Next-state, counter, and the accept/load/read-path qualifiers.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_enter_resp = 1'b0;
        w_load       = load_en && (r_state == S_IDLE);
        w_accept     = req_valid && !flush && (r_state != S_WAIT);

        if (flush) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        w_state_nxt  = c_ACCEPT_STATE;
                        w_count_nxt  = c_WAIT;
                        w_enter_resp = (c_ACCEPT_STATE == S_RESP);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT: begin
                    w_count_nxt = r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = 4'd0;
                end
            endcase
        end

        // From WAIT the latched address is read; otherwise the request itself
        // (zero-wait-state accept). A same-edge preload to the fetched word is
        // forwarded so the fetch sees the new data.
        w_fetch_addr  = (r_state == S_WAIT) ? r_addr : req_addr;
        w_fetch_idx   = w_fetch_addr[ADDR_BITS+1:2];
        w_fetch_misal = (w_fetch_addr[1:0] != 2'b00);
        w_fetch_word  = (w_load && (load_addr == w_fetch_idx)) ? load_data
                                                               : r_mem[w_fetch_idx];
    end

    // Instruction array; never reset so preloaded code survives a reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // State register, wait-state counter and the latched fetch address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_addr  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_addr <= req_addr;
            end
        end
    end

    // Registered response; misaligned fetches return a NOP with resp_err set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_instr <= 32'h0;
            r_resp_addr  <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_enter_resp;
            if (w_enter_resp) begin
                r_resp_instr <= w_fetch_misal ? 32'h0 : w_fetch_word;
                r_resp_addr  <= w_fetch_addr;
                r_resp_err   <= w_fetch_misal;
            end
        end
    end

    assign busy       = (r_state == S_WAIT);
    assign resp_valid = r_resp_valid;
    assign resp_instr = r_resp_instr;
    assign resp_addr  = r_resp_addr;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_responder
// Description : Self-checking bench for inst_fetch_responder (WAIT_CYCLES=2
//               instance plus a WAIT_CYCLES=0 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, flush, load_en;
    logic [31:0] req_addr, load_data;
    logic [7:0]  load_addr;
    logic        busy, resp_valid, resp_err;
    logic [31:0] resp_instr, resp_addr;

    logic        z_req_valid, z_flush, z_load_en;
    logic [31:0] z_req_addr, z_load_data;
    logic [7:0]  z_load_addr;
    logic        z_busy, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_instr, z_resp_addr;

    always #5 clk = ~clk;

    inst_fetch_responder #(.DEPTH(256), .ADDR_BITS(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .flush(flush), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .busy(busy), .resp_valid(resp_valid),
        .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_err(resp_err)
    );

    inst_fetch_responder #(.DEPTH(256), .ADDR_BITS(8), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_addr(z_req_addr),
        .flush(z_flush), .load_en(z_load_en), .load_addr(z_load_addr),
        .load_data(z_load_data), .busy(z_busy), .resp_valid(z_resp_valid),
        .resp_instr(z_resp_instr), .resp_addr(z_resp_addr), .resp_err(z_resp_err)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a fetch accepted at edge k is due at edge k+W; the next
    // accept is allowed from edge k+W+1 and the next preload from k+W+2.
    logic [31:0] mem_m [256];
    int          e = 0;
    bit          have_pend = 0;
    int          pend_due = 0;
    logic [31:0] pend_addr, pend_instr;
    bit          pend_err;
    int          acc_ok = 0;
    int          ld_ok  = 0;

    task automatic step();
        bit acc, ld, exp_busy, exp_rv;
        ld  = load_en && (e >= ld_ok);
        acc = req_valid && !flush && (e >= acc_ok);
        if (ld) mem_m[load_addr] = load_data;
        if (flush) begin
            if (have_pend && pend_due >= e) have_pend = 0;
            acc_ok = e + 1;
            ld_ok  = e + 1;
        end
        if (acc) begin
            have_pend  = 1;
            pend_due   = e + W;
            pend_addr  = req_addr;
            pend_err   = (req_addr[1:0] != 2'b00);
            pend_instr = pend_err ? 32'h0 : mem_m[req_addr[9:2]];
            acc_ok     = e + W + 1;
            ld_ok      = e + W + 2;
        end
        @(posedge clk);
        @(negedge clk);
        exp_busy = have_pend && (e < pend_due);
        exp_rv   = have_pend && (e == pend_due);
        check($sformatf("model_busy@%0d", e), busy, exp_busy);
        check($sformatf("model_rv@%0d", e), resp_valid, exp_rv);
        if (exp_rv) begin
            check($sformatf("model_instr@%0d", e), resp_instr, pend_instr);
            check($sformatf("model_addr@%0d", e), resp_addr, pend_addr);
            check($sformatf("model_err@%0d", e), resp_err, pend_err);
        end
        e++;
    endtask

    task automatic expect_now(input string n, input bit b, input bit v,
                              input logic [31:0] ins, input logic [31:0] ad, input bit er);
        check({n, "_busy"}, busy, b);
        check({n, "_rv"}, resp_valid, v);
        if (v) begin
            check({n, "_instr"}, resp_instr, ins);
            check({n, "_addr"}, resp_addr, ad);
            check({n, "_err"}, resp_err, er);
        end
    endtask

    task automatic fetch(input string n, input logic [31:0] a, input logic [31:0] ins, input bit er);
        req_valid = 1; req_addr = a;
        step(); expect_now({n, "_w1"}, 1, 0, 0, 0, 0);
        req_valid = 0;
        step(); expect_now({n, "_w2"}, 1, 0, 0, 0, 0);
        step(); expect_now({n, "_resp"}, 0, 1, ins, a, er);
    endtask

    task automatic z_check(input string n, input bit v, input logic [31:0] ins,
                           input logic [31:0] ad, input bit er);
        check({n, "_busy"}, z_busy, 0);
        check({n, "_rv"}, z_resp_valid, v);
        if (v) begin
            check({n, "_instr"}, z_resp_instr, ins);
            check({n, "_addr"}, z_resp_addr, ad);
            check({n, "_err"}, z_resp_err, er);
        end
    endtask

    typedef struct {
        bit          rv_in;
        logic [31:0] addr;
        bit          fl;
        bit          e_busy;
        bit          e_rv;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'hE3A00001; prog[1] = 32'hE3A01002;
        prog[2] = 32'hE0802001; prog[3] = 32'hEAFFFFFE;

        tbl[0] = '{1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE3A00001, 32'h0};
        tbl[3] = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 32'hE3A01002, 32'h4};
        tbl[6] = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE0802001, 32'h8};
        tbl[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

        rst = 0; req_valid = 0; req_addr = 0; flush = 0;
        load_en = 0; load_addr = 0; load_data = 0;
        z_req_valid = 0; z_req_addr = 0; z_flush = 0;
        z_load_en = 0; z_load_addr = 0; z_load_data = 0;

        #1;
        check("rst_busy", busy, 0);
        check("rst_rv", resp_valid, 0);
        check("rst_err", resp_err, 0);
        check("rst_instr", resp_instr, 32'h0);
        check("rst_addr", resp_addr, 32'h0);
        @(negedge clk);
        rst = 1;

        // Preload the whole array: the program at 0..3, random words elsewhere.
        for (int i = 0; i < 256; i++) begin
            load_en   = 1;
            load_addr = 8'(i);
            load_data = (i < 4) ? prog[i] : $urandom;
            step();
        end
        load_en = 0;

        // Single fetch, then back-to-back fetches accepted during RESP.
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].rv_in; req_addr = tbl[i].addr; flush = tbl[i].fl;
            step();
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_rv", i), resp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                check($sformatf("tbl%0d_instr", i), resp_instr, tbl[i].e_instr);
                check($sformatf("tbl%0d_addr", i), resp_addr, tbl[i].e_addr);
            end
        end
        req_valid = 0; flush = 0;

        // Flush in the first wait cycle drops the fetch.
        req_valid = 1; req_addr = 32'h4;
        step(); expect_now("fl_acc", 1, 0, 0, 0, 0);
        req_valid = 0; flush = 1;
        step(); expect_now("fl_drop", 0, 0, 0, 0, 0);
        flush = 0; req_valid = 1; req_addr = 32'hC;
        step(); expect_now("fl_noresp", 1, 0, 0, 0, 0);
        req_valid = 0;
        step(); expect_now("fl_w2", 1, 0, 0, 0, 0);
        step(); expect_now("fl_next", 0, 1, 32'hEAFFFFFE, 32'hC, 0);

        // Misaligned request and address wrap.
        fetch("misal", 32'h402, 32'h0, 1);
        fetch("wrap", 32'h400, 32'hE3A00001, 0);

        // Asynchronous reset in the middle of a wait.
        req_valid = 1; req_addr = 32'h0;
        step();
        req_valid = 0;
        #2 rst = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rv", resp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("arst_hold_rv", resp_valid, 0);
        rst = 1;
        have_pend = 0; acc_ok = e; ld_ok = e;
        step(); expect_now("arst_idle1", 0, 0, 0, 0, 0);
        step(); expect_now("arst_idle2", 0, 0, 0, 0, 0);
        fetch("arst_after", 32'h0, 32'hE3A00001, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_addr  = $urandom;
            if ($urandom_range(0, 3) != 0) req_addr[1:0] = 2'b00;
            flush     = ($urandom_range(0, 19) == 0);
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = 8'($urandom);
            load_data = $urandom;
            step();
        end
        req_valid = 0; flush = 0; load_en = 0;
        step();

        // Zero-wait-state instance.
        z_load_en = 1; z_load_addr = 8'd2; z_load_data = 32'hE0802001;
        z_req_valid = 1; z_req_addr = 32'h8;
        @(posedge clk); @(negedge clk);
        z_check("z_ldacc", 1, 32'hE0802001, 32'h8, 0);
        z_load_en = 0;
        @(posedge clk); @(negedge clk);
        z_check("z_b2b", 1, 32'hE0802001, 32'h8, 0);
        z_req_valid = 0; z_load_en = 1; z_load_data = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        z_check("z_ldresp", 0, 0, 0, 0);
        z_load_en = 0; z_req_valid = 1;
        @(posedge clk); @(negedge clk);
        z_check("z_ignored_ld", 1, 32'hE0802001, 32'h8, 0);
        z_req_addr = 32'h9;
        @(posedge clk); @(negedge clk);
        z_check("z_misal", 1, 32'h0, 32'h9, 1);
        z_req_addr = 32'h8; z_flush = 1;
        @(posedge clk); @(negedge clk);
        z_check("z_flush", 0, 0, 0, 0);
        z_req_valid = 0; z_flush = 0;
        @(posedge clk); @(negedge clk);
        z_check("z_idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
